// File: rtl/spi_rx_fifo.sv
// SPI slave receiver: synchronised, mode/bit-order selectable deserialiser feeding a FWFT FIFO.
// Optional macro SPI_RX_STICKY_ERR_EN adds clr_flags and makes the error flags sticky.
module spi_rx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     spi_clk,
  input  logic                     data_in,
  input  logic                     chip_select,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     done_flag,
  output logic                     over_flow,
  output logic                     under_flow,
  output logic                     frame_error
`ifdef SPI_RX_STICKY_ERR_EN
  ,
  input  logic                     clr_flags
`endif
);

  localparam int   AW          = $clog2(DEPTH);
  localparam int   CW          = $clog2(WIDTH);
  localparam logic CLK_IDLE    = 1'(CPOL);
  localparam bit   SAMPLE_RISE = ((CPOL ^ CPHA) == 0);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [1:0]       sclk_sync_r, mosi_sync_r, cs_sync_r;
  logic             sclk_prev_r;
  logic             sample_edge_s;
  state_t           state_r, state_s;
  logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [WIDTH-1:0] shift_r, shift_s, shifted_s;
  logic             done_s, frame_err_s;
  logic             push_r;
  logic [WIDTH-1:0] word_r;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_next_s, rd_next_s, count_s, count_next_s;
  logic             full_s, empty_s, pop_s, wr_ok_s, ovf_s, unf_s;
  logic [WIDTH-1:0] head_s;

`ifdef SPI_RX_STICKY_ERR_EN
  function automatic logic sticky_next(input logic evt, input logic cur, input logic clr);
    sticky_next = evt | (cur & ~clr);
  endfunction
`endif

  // Two-flop synchronisers; spi_clk resets to its idle level so release never fakes an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_sync_r <= {2{CLK_IDLE}};
      mosi_sync_r <= 2'b00;
      cs_sync_r   <= 2'b11;
      sclk_prev_r <= CLK_IDLE;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], spi_clk};
      mosi_sync_r <= {mosi_sync_r[0], data_in};
      cs_sync_r   <= {cs_sync_r[0], chip_select};
      sclk_prev_r <= sclk_sync_r[1];
    end
  end

  assign sample_edge_s = SAMPLE_RISE ? (sclk_sync_r[1] & ~sclk_prev_r)
                                     : (~sclk_sync_r[1] & sclk_prev_r);

  // Receive FSM next-state, shift and bit-count logic
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    done_s      = 1'b0;
    frame_err_s = 1'b0;
    if (MSB_FIRST != 0) begin
      shifted_s = {shift_r[WIDTH-2:0], mosi_sync_r[1]};
    end else begin
      shifted_s = {mosi_sync_r[1], shift_r[WIDTH-1:1]};
    end
    case (state_r)
      IDLE: begin
        if (!cs_sync_r[1]) begin
          state_s   = ACTIVE;
          bit_cnt_s = '0;
        end else begin
          state_s   = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_sync_r[1]) begin
          state_s     = IDLE;
          frame_err_s = (bit_cnt_r != '0);
          bit_cnt_s   = '0;
          shift_s     = '0;
        end else if (sample_edge_s) begin
          shift_s = shifted_s;
          if (bit_cnt_r == CW'(WIDTH - 1)) begin
            done_s    = 1'b1;
            bit_cnt_s = '0;
          end else begin
            bit_cnt_s = bit_cnt_r + CW'(1);
          end
        end else begin
          state_s = ACTIVE;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = '0;
      end
    endcase
  end

  // Receive FSM state, completed-word handoff register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      done_flag <= 1'b0;
      push_r    <= 1'b0;
      word_r    <= '0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      done_flag <= done_s;
      push_r    <= done_s;
      if (done_s) begin
        word_r <= shifted_s;
      end
    end
  end

  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign full_s       = (count_s == (AW+1)'(DEPTH));
  assign empty_s      = (count_s == '0);
  assign pop_s        = rd_en & ~empty_s;
  assign unf_s        = rd_en & empty_s;
  assign wr_ok_s      = push_r & (~full_s | pop_s);
  assign ovf_s        = push_r & full_s & ~pop_s;
  assign rd_next_s    = rd_ptr_r + {{AW{1'b0}}, pop_s};
  assign wr_next_s    = wr_ptr_r + {{AW{1'b0}}, wr_ok_s};
  assign count_next_s = wr_next_s - rd_next_s;

  // Head after this cycle's update; bypasses the write when it lands on the new read slot
  always_comb begin
    if (count_next_s == '0) begin
      head_s = '0;
    end else if (wr_ok_s && (wr_ptr_r[AW-1:0] == rd_next_s[AW-1:0])) begin
      head_s = word_r;
    end else begin
      head_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  // FIFO storage, pointers and registered head/status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= word_r;
      end
      wr_ptr_r   <= wr_next_s;
      rd_ptr_r   <= rd_next_s;
      data_out   <= head_s;
      data_valid <= (count_next_s != '0);
      fifo_count <= count_next_s;
    end
  end

  // Error flags: single-cycle pulses, or set-dominant sticky bits when enabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      over_flow   <= 1'b0;
      under_flow  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
`ifdef SPI_RX_STICKY_ERR_EN
      over_flow   <= sticky_next(ovf_s, over_flow, clr_flags);
      under_flow  <= sticky_next(unf_s, under_flow, clr_flags);
      frame_error <= sticky_next(frame_err_s, frame_error, clr_flags);
`else
      over_flow   <= ovf_s;
      under_flow  <= unf_s;
      frame_error <= frame_err_s;
`endif
    end
  end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed bench for spi_rx_fifo: instance a is mode 0 MSB-first, instance b is mode 3 LSB-first.
module tb_spi_rx_fifo;

  logic       clk, reset;
  logic       sclk_a, mosi_a, cs_a, rd_a;
  logic       sclk_b, mosi_b, cs_b, rd_b;
  logic [7:0] dout_a, dout_b;
  logic [2:0] cnt_a, cnt_b;
  logic       dv_a, done_a, ovf_a, unf_a, fe_a;
  logic       dv_b, done_b, ovf_b, unf_b, fe_b;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt_a = 0, ovf_cnt_a = 0, fe_cnt_a = 0;
  logic pop_pend = 1'b0;

  spi_rx_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_dut_a (
    .clock(clk), .reset(reset), .spi_clk(sclk_a), .data_in(mosi_a), .chip_select(cs_a),
    .rd_en(rd_a), .data_out(dout_a), .data_valid(dv_a), .fifo_count(cnt_a),
    .done_flag(done_a), .over_flow(ovf_a), .under_flow(unf_a), .frame_error(fe_a)
`ifdef SPI_RX_STICKY_ERR_EN
    , .clr_flags(1'b0)
`endif
  );

  spi_rx_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut_b (
    .clock(clk), .reset(reset), .spi_clk(sclk_b), .data_in(mosi_b), .chip_select(cs_b),
    .rd_en(rd_b), .data_out(dout_b), .data_valid(dv_b), .fifo_count(cnt_b),
    .done_flag(done_b), .over_flow(ovf_b), .under_flow(unf_b), .frame_error(fe_b)
`ifdef SPI_RX_STICKY_ERR_EN
    , .clr_flags(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for instance a, sampled mid-cycle
  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (ovf_a)  ovf_cnt_a++;
    if (fe_a)   fe_cnt_a++;
  end

  task automatic tick();
    @(negedge clk);
    rd_a = 1'b0;
    rd_b = 1'b0;
    if (pop_pend && done_a) begin
      rd_a     = 1'b1;
      pop_pend = 1'b0;
    end
  endtask

  task automatic set_cs(input int inst, input logic v);
    if (inst == 0) cs_a = v; else cs_b = v;
    repeat (4) tick();
  endtask

  // Each bit: data set up, leave idle level, return to idle; 3 system clocks per phase
  task automatic send_bits(input int inst, input logic [7:0] word, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = (inst == 0) ? word[7-i] : word[i];
      if (inst == 0) mosi_a = b; else mosi_b = b;
      repeat (3) tick();
      if (inst == 0) sclk_a = 1'b1; else sclk_b = 1'b0;
      repeat (3) tick();
      if (inst == 0) sclk_a = 1'b0; else sclk_b = 1'b1;
      repeat (3) tick();
    end
    repeat (2) tick();
  endtask

  task automatic pop(input int inst, input logic [7:0] exp);
    logic [8:0] got;
    got = (inst == 0) ? {dv_a, dout_a} : {dv_b, dout_b};
    n_total++;
    if (got !== {1'b1, exp}) $display("FAIL pop%0d: got valid/data %h, want %h", inst, got, {1'b1, exp});
    else n_pass++;
    if (inst == 0) rd_a = 1'b1; else rd_b = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_total++;
    if ({dout_a, dv_a, cnt_a, done_a, ovf_a, unf_a, fe_a} !== 16'h0000)
      $display("FAIL reset_a: got %h, want 0", {dout_a, dv_a, cnt_a, done_a, ovf_a, unf_a, fe_a});
    else n_pass++;
    n_total++;
    if ({dout_b, dv_b, cnt_b, done_b, ovf_b, unf_b, fe_b} !== 16'h0000)
      $display("FAIL reset_b: got %h, want 0", {dout_b, dv_b, cnt_b, done_b, ovf_b, unf_b, fe_b});
    else n_pass++;
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_mode0();
    set_cs(0, 1'b0);
    send_bits(0, 8'hA5, 7);
    mosi_a = 1'b1;
    repeat (3) tick();
    sclk_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (done_a !== 1'b0) $display("FAIL mode0_early_done: got %b, want 0", done_a); else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (done_a !== 1'b1) $display("FAIL mode0_done_lat3: got %b, want 1", done_a); else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({done_a, dout_a, dv_a, cnt_a} !== {1'b0, 8'hA5, 1'b1, 3'd1})
      $display("FAIL mode0_head: got done/data/valid/count %h, want %h",
               {done_a, dout_a, dv_a, cnt_a}, {1'b0, 8'hA5, 1'b1, 3'd1});
    else n_pass++;
    tick();
    sclk_a = 1'b0;
    repeat (3) tick();
    pop(0, 8'hA5);
    set_cs(0, 1'b1);
  endtask

  task automatic test_mode3_back_to_back();
    set_cs(1, 1'b0);
    send_bits(1, 8'h3C, 8);
    send_bits(1, 8'h81, 8);
    n_total++;
    if (cnt_b !== 3'd2) $display("FAIL mode3_count2: got %0d, want 2", cnt_b); else n_pass++;
    pop(1, 8'h3C);
    pop(1, 8'h81);
    n_total++;
    if ({dv_b, cnt_b} !== 4'h0) $display("FAIL mode3_drained: got %h, want 0", {dv_b, cnt_b}); else n_pass++;
    set_cs(1, 1'b1);
  endtask

  task automatic test_overflow();
    int o0;
    set_cs(0, 1'b0);
    o0 = ovf_cnt_a;
    send_bits(0, 8'h11, 8);
    send_bits(0, 8'h22, 8);
    send_bits(0, 8'h33, 8);
    send_bits(0, 8'h44, 8);
    n_total++;
    if ({cnt_a, ovf_cnt_a - o0} !== {3'd4, 32'd0})
      $display("FAIL ovf_fill4: got count %0d ovf %0d, want 4 and 0", cnt_a, ovf_cnt_a - o0);
    else n_pass++;
    send_bits(0, 8'h55, 8);
    n_total++;
    if ({cnt_a, ovf_cnt_a - o0} !== {3'd4, 32'd1})
      $display("FAIL ovf_fifth: got count %0d ovf %0d, want 4 and 1", cnt_a, ovf_cnt_a - o0);
    else n_pass++;
    pop(0, 8'h11);
    pop(0, 8'h22);
    pop(0, 8'h33);
    pop(0, 8'h44);
    n_total++;
    if ({dv_a, cnt_a} !== 4'h0) $display("FAIL ovf_drained: got %h, want 0", {dv_a, cnt_a}); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    int o0;
    send_bits(0, 8'h61, 8);
    send_bits(0, 8'h62, 8);
    send_bits(0, 8'h63, 8);
    send_bits(0, 8'h64, 8);
    o0 = ovf_cnt_a;
    pop_pend = 1'b1;
    send_bits(0, 8'h65, 8);
    n_total++;
    if ({cnt_a, dout_a, ovf_cnt_a - o0} !== {3'd4, 8'h62, 32'd0})
      $display("FAIL full_push_pop: got count %0d head %h ovf %0d, want 4 62 0",
               cnt_a, dout_a, ovf_cnt_a - o0);
    else n_pass++;
    pop(0, 8'h62);
    pop(0, 8'h63);
    pop(0, 8'h64);
    pop(0, 8'h65);
  endtask

  task automatic test_underflow();
    rd_a = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if ({unf_a, cnt_a} !== {1'b1, 3'd0})
      $display("FAIL underflow: got flag/count %h, want %h", {unf_a, cnt_a}, {1'b1, 3'd0});
    else n_pass++;
    tick();
    @(posedge clk);
    #1;
    n_total++;
    if ({unf_a, cnt_a} !== 4'h0) $display("FAIL underflow_pulse: got %h, want 0", {unf_a, cnt_a}); else n_pass++;
    tick();
    set_cs(0, 1'b1);
  endtask

  task automatic test_frame_error();
    int f0, d0;
    set_cs(0, 1'b0);
    f0 = fe_cnt_a;
    d0 = done_cnt_a;
    send_bits(0, 8'hF0, 5);
    set_cs(0, 1'b1);
    repeat (2) tick();
    n_total++;
    if ({fe_cnt_a - f0, done_cnt_a - d0, 29'd0, cnt_a} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL frame_error: got fe %0d done %0d count %0d, want 1 0 0",
               fe_cnt_a - f0, done_cnt_a - d0, cnt_a);
    else n_pass++;
  endtask

  task automatic test_reset_midword();
    set_cs(0, 1'b0);
    send_bits(0, 8'h77, 8);
    send_bits(0, 8'hFF, 4);
    reset = 1'b0;
    tick();
    n_total++;
    if ({dout_a, dv_a, cnt_a, done_a, ovf_a, unf_a, fe_a} !== 16'h0000)
      $display("FAIL reset_midword: got %h, want 0", {dout_a, dv_a, cnt_a, done_a, ovf_a, unf_a, fe_a});
    else n_pass++;
    reset = 1'b1;
    repeat (5) tick();
    send_bits(0, 8'hC3, 8);
    n_total++;
    if ({cnt_a, dout_a} !== {3'd1, 8'hC3})
      $display("FAIL after_reset_word: got count %0d data %h, want 1 c3", cnt_a, dout_a);
    else n_pass++;
    pop(0, 8'hC3);
    set_cs(0, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    sclk_a = 1'b0; mosi_a = 1'b0; cs_a = 1'b1; rd_a = 1'b0;
    sclk_b = 1'b1; mosi_b = 1'b0; cs_b = 1'b1; rd_b = 1'b0;
    tick();
    test_reset();
    test_mode0();
    test_mode3_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_frame_error();
    test_reset_midword();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
